systolic_bank_ctrl: RTL and testbench
=====================================

Name: systolic_bank_ctrl

Overview:
Sequencer for the 3x4 systolic PE bank and its four column accumulators. It latches a job descriptor on start and issues the one-cycle PE configuration load. It then streams feature beats over one or more accumulation passes and drives the per-column accumulator enable (G) and first-beat overwrite (F) strobes, skewed to match the bank's column wavefront. It sits between the feature/weight buffer front-end and the bank.

Parameters:
NCOLS, 4, number of PE columns / accumulators
NROWS, 3, number of PE rows (iconfig width)
LEN_W, 10, width of beats-per-pass count
PASS_W, 8, width of pass count
PIPE_LAT, 3, cycles from in_en at column 1 to valid psum at accumulator 1

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
start  in  1  job request; sampled only in IDLE
len  in  LEN_W  beats per pass; sampled with start
passes  in  PASS_W  accumulation passes; sampled with start; 0 is treated as 1
iconfig_in  in  NROWS  per-row PE config; sampled with start
ctrl_word  in  5*NCOLS  per-column A..E controls; bit [5*c+k] drives column c, field k (A=0..E=4); sampled with start
feat_valid  in  1  feature/weight source has a beat
feat_ready  out  1  controller accepts a beat
in_en  out  1  bank in_en = feat_valid & feat_ready
config_load  out  1  one-cycle PE config strobe
iconfig  out  NROWS  latched iconfig_in; bit r drives iconfig_(r+1)
a_out, b_out, c_out, d_out, e_out  out  NCOLS each  latched per-column A..E
g_out  out  NCOLS  accumulator in_en (G_c)
f_out  out  NCOLS  accumulator overwrite strobe (F_c)
busy  out  1  not IDLE
done  out  1  one-cycle job-complete pulse
pass_idx  out  PASS_W  current pass, 0-based

Behaviour:
- Reset (rst=0, async): FSM=IDLE; all outputs and counters 0, including latched config and delay lines.
- States: IDLE, CONFIG, STREAM, DRAIN, DONE.
- IDLE:
  - start=1 -> latch len, passes (0->1), iconfig_in, ctrl_word; go to CONFIG.
  - start is ignored in every other state.
- CONFIG (1 cycle):
  - config_load=1.
  - len==0 -> DONE.
  - Else -> STREAM with beat_cnt=0, pass_idx=0.
- STREAM:
  - feat_ready=1; in_en=feat_valid.
  - Each accepted beat increments beat_cnt.
  - On the beat making beat_cnt==len: reset beat_cnt and go to DRAIN.
  - feat_valid low stalls with no penalty; the gap propagates as a bubble in g_out.
- DRAIN:
  - feat_ready=0.
  - Wait exactly PIPE_LAT+NCOLS-1 cycles after the last accepted beat, i.e. until the last G pulse has been issued.
  - Then: pass_idx<passes-1 -> pass_idx++ and back to STREAM; otherwise -> DONE.
- DONE (1 cycle): done=1 -> IDLE. busy=0 only in IDLE.
- Skew, with c = 0..NCOLS-1:
  - g_out[c] = in_en delayed by PIPE_LAT+c cycles via a registered shift line.
  - f_out[c] = (in_en & first beat of pass 0) delayed identically, so each accumulator overwrites on its first valid psum and adds thereafter.
- Hold rules:
  - a..e_out and iconfig hold their latched values from CONFIG through DONE.
  - In IDLE they keep the last job's values (no toggling).
- Async reset mid-job: immediate return to IDLE; delay lines cleared so no stray G/F pulses; done not asserted.
- Counters saturate-free: len and passes are bounded by their widths. len = 2^LEN_W-1 must work.

Test Plan:
- Basic job: len=4, passes=1, feat_valid held 1 -> config_load one cycle after start. in_en 4 cycles. g_out[0] high cycles 4+3..7+3 after in_en start (delay 3). g_out[3] delayed 3 more. f_out[c] one pulse on first G of each column. done after 6 drain cycles.
- Multi-pass: len=3, passes=2 -> pass_idx 0 then 1. 6 in_en beats in two bursts separated by a 6-cycle drain. f_out pulses only in pass 0. Exactly one done.
- Stall: len=4, feat_valid pattern 1,0,0,1,1,1 -> in_en and g_out[c] reproduce the same 2-cycle bubble shifted by 3+c. Beat count is still 4.
- Edge descriptors: len=0 -> config_load then done, no in_en/g_out. passes=0 behaves as passes=1. start held high during busy is ignored, and a new job starts only once IDLE is reached.
- Config latch: ctrl_word=0xA5A5A, iconfig_in=3'b101 at start; inputs changed to 0 mid-job -> a..e_out/iconfig unchanged through DONE.
- Reset mid-STREAM after 2 beats: rst low for 1 cycle -> all outputs 0 immediately, no later g_out/done pulses. A new start then runs a clean job.

Source files
------------

// File: rtl/systolic_bank_ctrl_if.sv
// rtl/systolic_bank_ctrl_if.sv - job descriptor, feature handshake and bank strobes
interface systolic_bank_ctrl_if #(
  parameter int NCOLS  = 4,
  parameter int NROWS  = 3,
  parameter int LEN_W  = 10,
  parameter int PASS_W = 8
);
  logic                 start;
  logic [LEN_W-1:0]     len;
  logic [PASS_W-1:0]    passes;
  logic [NROWS-1:0]     iconfig_in;
  logic [5*NCOLS-1:0]   ctrl_word;
  logic                 feat_valid;
  logic                 feat_ready;
  logic                 in_en;
  logic                 config_load;
  logic [NROWS-1:0]     iconfig;
  logic [NCOLS-1:0]     a_out, b_out, c_out, d_out, e_out;
  logic [NCOLS-1:0]     g_out;
  logic [NCOLS-1:0]     f_out;
  logic                 busy;
  logic                 done;
  logic [PASS_W-1:0]    pass_idx;

  modport master (
    output start, len, passes, iconfig_in, ctrl_word, feat_valid,
    input  feat_ready, in_en, config_load, iconfig, a_out, b_out, c_out, d_out, e_out,
           g_out, f_out, busy, done, pass_idx
  );

  modport slave (
    input  start, len, passes, iconfig_in, ctrl_word, feat_valid,
    output feat_ready, in_en, config_load, iconfig, a_out, b_out, c_out, d_out, e_out,
           g_out, f_out, busy, done, pass_idx
  );
endinterface

// File: rtl/systolic_bank_ctrl.sv
// rtl/systolic_bank_ctrl.sv - job sequencer for the systolic PE bank and column accumulators
module systolic_bank_ctrl #(
  parameter int NCOLS    = 4,
  parameter int NROWS    = 3,
  parameter int LEN_W    = 10,
  parameter int PASS_W   = 8,
  parameter int PIPE_LAT = 3
) (
  input logic              clk,
  input logic              rst,
  systolic_bank_ctrl_if.slave bus
);
  localparam int DLY = PIPE_LAT + NCOLS - 1;
  localparam int DW  = $clog2(DLY + 1);

  typedef enum logic [2:0] {IDLE, CONFIG, STREAM, DRAIN, DONE} state_t;

  state_t             state;
  logic [LEN_W-1:0]   len_r, beat_cnt;
  logic [PASS_W-1:0]  passes_r, pass_idx;
  logic [DW-1:0]      drain_cnt;
  logic               feat_ready, config_load, busy, done;
  logic [NROWS-1:0]   iconfig;
  logic [NCOLS-1:0]   a_r, b_r, c_r, d_r, e_r;
  logic               in_en, first_beat;
  logic [DLY-1:0]     g_sr, f_sr;

  assign in_en      = bus.feat_valid & feat_ready;
  assign first_beat = in_en && (pass_idx == '0) && (beat_cnt == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      len_r       <= '0;
      beat_cnt    <= '0;
      passes_r    <= '0;
      pass_idx    <= '0;
      drain_cnt   <= '0;
      feat_ready  <= 1'b0;
      config_load <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      iconfig     <= '0;
      a_r         <= '0;
      b_r         <= '0;
      c_r         <= '0;
      d_r         <= '0;
      e_r         <= '0;
    end else begin
      config_load <= 1'b0;
      done        <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          len_r    <= bus.len;
          passes_r <= (bus.passes == '0) ? PASS_W'(1) : bus.passes;
          iconfig  <= bus.iconfig_in;
          for (int c = 0; c < NCOLS; c++) begin
            a_r[c] <= bus.ctrl_word[5*c];
            b_r[c] <= bus.ctrl_word[5*c+1];
            c_r[c] <= bus.ctrl_word[5*c+2];
            d_r[c] <= bus.ctrl_word[5*c+3];
            e_r[c] <= bus.ctrl_word[5*c+4];
          end
          pass_idx    <= '0;
          config_load <= 1'b1;
          busy        <= 1'b1;
          state       <= CONFIG;
        end
        CONFIG: if (len_r == '0) begin
          done  <= 1'b1;
          state <= DONE;
        end else begin
          beat_cnt   <= '0;
          pass_idx   <= '0;
          feat_ready <= 1'b1;
          state      <= STREAM;
        end
        STREAM: if (in_en) begin
          if (beat_cnt == len_r - LEN_W'(1)) begin
            beat_cnt   <= '0;
            drain_cnt  <= '0;
            feat_ready <= 1'b0;
            state      <= DRAIN;
          end else begin
            beat_cnt <= beat_cnt + LEN_W'(1);
          end
        end
        // Leave only after the last column has seen its final G pulse.
        DRAIN: if (drain_cnt == DW'(DLY - 1)) begin
          if (pass_idx == passes_r - PASS_W'(1)) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            pass_idx   <= pass_idx + PASS_W'(1);
            feat_ready <= 1'b1;
            state      <= STREAM;
          end
        end else begin
          drain_cnt <= drain_cnt + DW'(1);
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Bit k of each line is in_en delayed k+1 cycles; column c taps delay PIPE_LAT+c.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      g_sr <= '0;
      f_sr <= '0;
    end else begin
      g_sr <= {g_sr[DLY-2:0], in_en};
      f_sr <= {f_sr[DLY-2:0], first_beat};
    end
  end

  assign bus.feat_ready  = feat_ready;
  assign bus.in_en       = in_en;
  assign bus.config_load = config_load;
  assign bus.iconfig     = iconfig;
  assign bus.a_out       = a_r;
  assign bus.b_out       = b_r;
  assign bus.c_out       = c_r;
  assign bus.d_out       = d_r;
  assign bus.e_out       = e_r;
  assign bus.g_out       = g_sr[DLY-1:PIPE_LAT-1];
  assign bus.f_out       = f_sr[DLY-1:PIPE_LAT-1];
  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.pass_idx    = pass_idx;
endmodule

// File: tb/tb_systolic_bank_ctrl.sv
// tb/tb_systolic_bank_ctrl.sv - scoreboard bench for systolic_bank_ctrl
module tb_systolic_bank_ctrl;
  localparam int LAT   = 3;
  localparam int NCOLS = 4;
  localparam int BIG   = 1 << 30;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  systolic_bank_ctrl_if ifc ();
  systolic_bank_ctrl dut (.clk(clk), .rst(rst), .bus(ifc));

  typedef struct {
    int cyc; int cl; int ie; int g; int f; int dn; int pidx; int busy; int cfg;
  } ev_t;

  ev_t expq[$];
  bit  fv_sched[int];
  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  bit  mon_en = 1'b0;
  int  none[$];
  int  stall_pat[$] = '{1, 0, 0, 1, 1, 1};

  function automatic int cfg_of(int ctrl, int icfg);
    int fld[5] = '{0, 0, 0, 0, 0};
    for (int c = 0; c < NCOLS; c++)
      for (int k = 0; k < 5; k++)
        fld[k] |= ((ctrl >> (5*c + k)) & 1) << c;
    return (icfg << 20) | (fld[4] << 16) | (fld[3] << 12) | (fld[2] << 8) | (fld[1] << 4) | fld[0];
  endfunction

  function automatic bit fv(int x);
    return fv_sched.exists(x) ? fv_sched[x] : 1'b0;
  endfunction

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Expected timeline of one job whose CONFIG cycle is S; events at or after S+cut are dropped.
  task automatic plan(input int S, input int len, input int passes, input int pat[$],
                      input int ctrl, input int icfg, input int cut, output int D);
    int ie_m[int], g_m[int], f_m[int], pm[int];
    int P, c, cnt, j, sp, last, v, cf;
    ev_t e;
    cf = cfg_of(ctrl, icfg);
    P  = (passes == 0) ? 1 : passes;
    c  = S + 1;
    last = S;
    if (len == 0) D = S + 1;
    else begin
      for (int p = 0; p < P; p++) begin
        sp = c; cnt = 0; j = 0;
        while (cnt < len) begin
          v = (j < pat.size()) ? pat[j] : 1;
          fv_sched[c] = v[0];
          if (v != 0) begin
            ie_m[c] = 1;
            for (int col = 0; col < NCOLS; col++) begin
              if (!g_m.exists(c + LAT + col)) g_m[c + LAT + col] = 0;
              g_m[c + LAT + col] |= 1 << col;
              if (p == 0 && cnt == 0) f_m[c + LAT + col] = 1 << col;
            end
            cnt++;
            last = c;
          end
          c++; j++;
        end
        for (int x = sp; x <= last + LAT + NCOLS - 1; x++) pm[x] = p;
        c = last + LAT + NCOLS;
      end
      D = c;
    end
    for (int x = S; x <= D; x++) begin
      e.cyc  = x;
      e.cl   = (x == S) ? 1 : 0;
      e.dn   = (x == D) ? 1 : 0;
      e.ie   = ie_m.exists(x) ? ie_m[x] : 0;
      e.g    = g_m.exists(x) ? g_m[x] : 0;
      e.f    = f_m.exists(x) ? f_m[x] : 0;
      e.pidx = (x == D) ? ((len == 0) ? 0 : P - 1) : (pm.exists(x) ? pm[x] : 0);
      e.busy = 1;
      e.cfg  = cf;
      if ((e.cl | e.dn | e.ie | e.g | e.f) != 0 && x < S + cut) expq.push_back(e);
    end
  endtask

  task automatic run_job(input int len, input int passes, input int ctrl, input int icfg,
                         input int pat[$], input bit hold, input int cut, output int D);
    int S;
    S = cyc + 1;
    plan(S, len, passes, pat, ctrl, icfg, cut, D);
    ifc.len        = 10'(len);
    ifc.passes     = 8'(passes);
    ifc.ctrl_word  = 20'(ctrl);
    ifc.iconfig_in = 3'(icfg);
    ifc.start      = 1'b1;
    ifc.feat_valid = 1'b0;
    tick();
    if (!hold) ifc.start = 1'b0;
    ifc.len = '0; ifc.passes = '0; ifc.ctrl_word = '0; ifc.iconfig_in = '0;
    ifc.feat_valid = fv(cyc);
    while (cyc < D + 1 && cyc < S + cut) begin
      tick();
      ifc.feat_valid = fv(cyc);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      tick();
      ifc.feat_valid = 1'b1;
    end
    ifc.feat_valid = 1'b0;
  endtask

  always @(negedge clk) begin : monitor
    ev_t a, e;
    if (mon_en) begin
      a.cyc = cyc; a.cl = int'(ifc.config_load); a.ie = int'(ifc.in_en);
      a.g = int'(ifc.g_out); a.f = int'(ifc.f_out); a.dn = int'(ifc.done);
      a.pidx = int'(ifc.pass_idx); a.busy = int'(ifc.busy);
      a.cfg = int'({ifc.iconfig, ifc.e_out, ifc.d_out, ifc.c_out, ifc.b_out, ifc.a_out});
      if ((a.cl | a.ie | a.g | a.f | a.dn) != 0) begin
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event cyc=%0d cl=%0d ie=%0d g=%h f=%h dn=%0d", a.cyc, a.cl, a.ie, a.g, a.f, a.dn);
        end else begin
          e = expq.pop_front();
          if (a.cyc != e.cyc || a.cl != e.cl || a.ie != e.ie || a.g != e.g || a.f != e.f ||
              a.dn != e.dn || a.pidx != e.pidx || a.busy != e.busy || a.cfg != e.cfg) begin
            errors++;
            $display("FAIL scoreboard actual cyc=%0d cl=%0d ie=%0d g=%h f=%h dn=%0d p=%0d busy=%0d cfg=%h required cyc=%0d cl=%0d ie=%0d g=%h f=%h dn=%0d p=%0d busy=%0d cfg=%h",
                     a.cyc, a.cl, a.ie, a.g, a.f, a.dn, a.pidx, a.busy, a.cfg,
                     e.cyc, e.cl, e.ie, e.g, e.f, e.dn, e.pidx, e.busy, e.cfg);
          end
        end
      end
    end
  end

  initial begin
    int D;
    ifc.start = 1'b0; ifc.len = '0; ifc.passes = '0; ifc.ctrl_word = '0;
    ifc.iconfig_in = '0; ifc.feat_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", int'(ifc.busy), 0);
    check("rst_feat_ready", int'(ifc.feat_ready), 0);
    check("rst_g_f", int'({ifc.g_out, ifc.f_out}), 0);
    check("rst_cfg", int'({ifc.iconfig, ifc.a_out, ifc.b_out, ifc.c_out, ifc.d_out, ifc.e_out}), 0);
    check("rst_pass_done", int'({ifc.pass_idx, ifc.done, ifc.config_load}), 0);
    rst = 1'b1;
    mon_en = 1'b1;
    idle(3);

    run_job(4, 1, 'hA5A5A, 'b101, none, 1'b0, BIG, D);
    idle(2);
    check("latched_a", int'(ifc.a_out), 'h0);
    check("latched_b", int'(ifc.b_out), 'h7);
    check("latched_c", int'(ifc.c_out), 'hC);
    check("latched_d", int'(ifc.d_out), 'h1);
    check("latched_e", int'(ifc.e_out), 'hF);
    check("latched_iconfig", int'(ifc.iconfig), 'b101);
    check("idle_busy", int'(ifc.busy), 0);

    run_job(3, 2, 'h12345, 'b010, none, 1'b0, BIG, D);
    idle(2);
    run_job(4, 1, 'h0F0F0, 'b011, stall_pat, 1'b0, BIG, D);
    idle(2);
    run_job(0, 1, 'h33333, 'b001, none, 1'b0, BIG, D);
    idle(2);
    run_job(2, 0, 'h55555, 'b110, none, 1'b0, BIG, D);
    idle(2);
    run_job(2, 1, 'h11111, 'b100, none, 1'b1, BIG, D);
    run_job(1, 1, 'h22222, 'b010, none, 1'b0, BIG, D);
    idle(2);

    run_job(4, 1, 'hFFFFF, 'b111, none, 1'b0, 3, D);
    rst = 1'b0;
    ifc.feat_valid = 1'b0;
    #1;
    check("midrst_busy", int'(ifc.busy), 0);
    check("midrst_g_f", int'({ifc.g_out, ifc.f_out, ifc.in_en, ifc.feat_ready}), 0);
    tick();
    rst = 1'b1;
    idle(8);
    check("midrst_cfg_cleared", int'({ifc.iconfig, ifc.a_out, ifc.e_out}), 0);
    run_job(3, 1, 'h0A0A0, 'b001, none, 1'b0, BIG, D);
    idle(2);

    run_job(1023, 1, 'h00001, 'b001, none, 1'b0, BIG, D);
    idle(10);
    check("queue_empty", expq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
